// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS2 keyboard controller.
//   t_frame_st : receive-frame FSM states (ps2_frame_rx)
//   t_dec_st   : prefix-decoder FSM states (ps2_kbd_ctrl)
//   t_kbd_ev   : one key event as stored in the event FIFO
package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_START,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } t_frame_st;

    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_GOT_E0,
        DEC_GOT_F0,
        DEC_GOT_E0F0
    } t_dec_st;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } t_kbd_ev;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS2 frame receiver: synchronises the PS2 clock/data pins, detects falling
// edges of the synchronised clock, frames start/8 data/parity/stop bits and
// supervises the gap between clock edges inside a frame.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   kbd_clk        PS2 clock pin (asynchronous)
//   kbd_data       PS2 data pin (asynchronous)
//   byte_o         last good byte, valid while byte_vld_o is high
//   byte_vld_o     1-cycle strobe, the cycle after the stop-bit edge
//   frame_err_o    1-cycle pulse on any discarded frame
//   parity_err_o   1-cycle pulse: parity or stop-bit failure
//   timeout_o      1-cycle pulse: mid-frame timeout
//   state_o        current frame FSM state (debug)
module ps2_frame_rx
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbd_clk,
    input  logic       kbd_data,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       timeout_o,
    output t_frame_st  state_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    t_frame_st              st_q, st_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [7:0]             byte_q, byte_d;
    logic                   byte_vld_q, byte_vld_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   timeout_q, timeout_d;

    logic clk_s;
    logic data_s;
    logic fall;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;

    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], kbd_clk};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], kbd_data};
        clk_prev_d   = clk_s;
        st_d         = st_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        byte_d       = byte_q;
        byte_vld_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        timeout_d    = 1'b0;

        // Gap counter restarts on every edge and only runs inside a frame.
        if (st_q == FR_IDLE || fall) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        case (st_q)
            FR_IDLE: begin
                // A falling edge with data high is line noise, not a start bit.
                if (fall && !data_s) begin
                    st_d = FR_START;
                end
            end
            FR_START: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = 3'd1;
                    st_d      = FR_DATA;
                end
            end
            FR_DATA: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        st_d = FR_PARITY;
                    end
                end
            end
            FR_PARITY: begin
                if (fall) begin
                    par_d = data_s;
                    st_d  = FR_STOP;
                end
            end
            FR_STOP: begin
                if (fall) begin
                    st_d = FR_IDLE;
                    // Odd parity over data+parity, and the stop bit must be high.
                    if (data_s && (^{shift_q, par_q})) begin
                        byte_d     = shift_q;
                        byte_vld_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                        parity_err_d = 1'b1;
                    end
                end
            end
            default: st_d = FR_IDLE;
        endcase

        if (st_q != FR_IDLE && !fall && tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            st_d        = FR_IDLE;
            tmo_cnt_d   = '0;
            frame_err_d = 1'b1;
            timeout_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Idle PS2 lines are high; preloading ones avoids a false edge after reset.
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            clk_prev_q   <= 1'b1;
            st_q         <= FR_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            byte_q       <= '0;
            byte_vld_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            st_q         <= st_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_cnt_q    <= tmo_cnt_d;
            byte_q       <= byte_d;
            byte_vld_q   <= byte_vld_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_vld_o   = byte_vld_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign timeout_o    = timeout_q;
    assign state_o      = st_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS2 keyboard controller top: receives frames via ps2_frame_rx, folds
// E0/F0 prefixes into key events, queues them in a first-word-fall-through
// FIFO and keeps sticky error flags for the MMIO register file.
// Ports:
//   Clk, RstN                   system clock, asynchronous active-low reset
//   KbdClk, KbdSerialData       PS2 pins (asynchronous)
//   EvPop                       pop head event
//   ClrErr                      clear sticky error bits
//   EvValid/EvCode/EvExt/EvBreak head event (all 0 when FIFO empty)
//   FrameErr                    1-cycle pulse per discarded frame
//   ParityErrSticky, TimeoutSticky, OverflowSticky  sticky error flags
//   FifoCount                   FIFO occupancy
//   DbgFrameSt, DbgDecSt        FSM states (debug)
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        Clk,
    input  logic                        RstN,
    input  logic                        KbdClk,
    input  logic                        KbdSerialData,
    input  logic                        EvPop,
    input  logic                        ClrErr,
    output logic                        EvValid,
    output logic [7:0]                  EvCode,
    output logic                        EvExt,
    output logic                        EvBreak,
    output logic                        FrameErr,
    output logic                        ParityErrSticky,
    output logic                        TimeoutSticky,
    output logic                        OverflowSticky,
    output logic [$clog2(FIFO_DEPTH):0] FifoCount,
    output t_frame_st                   DbgFrameSt,
    output t_dec_st                     DbgDecSt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_timeout;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk          (Clk),
        .rst_n        (RstN),
        .kbd_clk      (KbdClk),
        .kbd_data     (KbdSerialData),
        .byte_o       (rx_byte),
        .byte_vld_o   (rx_vld),
        .frame_err_o  (rx_frame_err),
        .parity_err_o (rx_parity_err),
        .timeout_o    (rx_timeout),
        .state_o      (DbgFrameSt)
    );

    t_dec_st          dec_st_q, dec_st_d;
    t_kbd_ev          mem_q [FIFO_DEPTH];
    t_kbd_ev          mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             par_st_q, par_st_d;
    logic             tmo_st_q, tmo_st_d;
    logic             ovf_st_q, ovf_st_d;

    logic    push;
    t_kbd_ev push_ev;
    logic    full;
    logic    pop_ok;
    logic    push_ok;
    t_kbd_ev head;

    // Prefix decoder: E0/F0 only move state; any other byte emits one event.
    always_comb begin
        dec_st_d = dec_st_q;
        push     = 1'b0;
        push_ev  = '0;
        if (rx_frame_err) begin
            dec_st_d = DEC_BASE;
        end else if (rx_vld) begin
            if (rx_byte == PS2_PFX_EXT) begin
                dec_st_d = DEC_GOT_E0;
            end else if (rx_byte == PS2_PFX_BRK) begin
                if (dec_st_q == DEC_BASE) begin
                    dec_st_d = DEC_GOT_F0;
                end else if (dec_st_q == DEC_GOT_E0) begin
                    dec_st_d = DEC_GOT_E0F0;
                end
            end else begin
                push         = 1'b1;
                push_ev.code = rx_byte;
                push_ev.ext  = (dec_st_q == DEC_GOT_E0) || (dec_st_q == DEC_GOT_E0F0);
                push_ev.brk  = (dec_st_q == DEC_GOT_F0) || (dec_st_q == DEC_GOT_E0F0);
                dec_st_d     = DEC_BASE;
            end
        end
    end

    // Consumer handshake: EvValid high means the head event is on EvCode/EvExt/
    // EvBreak; EvPop sampled on a clock edge with EvValid high removes it. EvPop
    // while EvValid is low has no effect. A pop frees a slot for a push in the
    // same cycle, so a full FIFO can accept a push together with a pop.
    always_comb begin
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        pop_ok   = EvPop && (count_q != '0);
        push_ok  = push && (!full || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_ev;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Setting wins over clearing in the same cycle.
        par_st_d = rx_parity_err | (par_st_q & ~ClrErr);
        tmo_st_d = rx_timeout | (tmo_st_q & ~ClrErr);
        ovf_st_d = (push && full && !pop_ok) | (ovf_st_q & ~ClrErr);
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            dec_st_q <= DEC_BASE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            par_st_q <= 1'b0;
            tmo_st_q <= 1'b0;
            ovf_st_q <= 1'b0;
        end else begin
            dec_st_q <= dec_st_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            par_st_q <= par_st_d;
            tmo_st_q <= tmo_st_d;
            ovf_st_q <= ovf_st_d;
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign EvValid         = (count_q != '0);
    assign EvCode          = EvValid ? head.code : 8'h00;
    assign EvExt           = EvValid & head.ext;
    assign EvBreak         = EvValid & head.brk;
    assign FrameErr        = rx_frame_err;
    assign ParityErrSticky = par_st_q;
    assign TimeoutSticky   = tmo_st_q;
    assign OverflowSticky  = ovf_st_q;
    assign FifoCount       = count_q;
    assign DbgDecSt        = dec_st_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: 100 MHz Clk, PS2 bit period of 1 us (100 Clk
// cycles) so that normal inter-edge gaps stay inside TIMEOUT_CYC=200.
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int HALF  = 50;

    logic       Clk = 1'b0;
    logic       RstN = 1'b0;
    logic       KbdClk = 1'b1;
    logic       KbdSerialData = 1'b1;
    logic       EvPop = 1'b0;
    logic       ClrErr = 1'b0;
    logic       EvValid;
    logic [7:0] EvCode;
    logic       EvExt;
    logic       EvBreak;
    logic       FrameErr;
    logic       ParityErrSticky;
    logic       TimeoutSticky;
    logic       OverflowSticky;
    logic [3:0] FifoCount;
    ps2_kbd_pkg::t_frame_st dbg_frame_st;
    ps2_kbd_pkg::t_dec_st   dbg_dec_st;

    ps2_kbd_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO),
        .SYNC_STAGES (2)
    ) dut (
        .Clk             (Clk),
        .RstN            (RstN),
        .KbdClk          (KbdClk),
        .KbdSerialData   (KbdSerialData),
        .EvPop           (EvPop),
        .ClrErr          (ClrErr),
        .EvValid         (EvValid),
        .EvCode          (EvCode),
        .EvExt           (EvExt),
        .EvBreak         (EvBreak),
        .FrameErr        (FrameErr),
        .ParityErrSticky (ParityErrSticky),
        .TimeoutSticky   (TimeoutSticky),
        .OverflowSticky  (OverflowSticky),
        .FifoCount       (FifoCount),
        .DbgFrameSt      (dbg_frame_st),
        .DbgDecSt        (dbg_dec_st)
    );

    // ---------------- clock / watchdog ----------------
    always #5 Clk = ~Clk;

    initial begin
        repeat (90000) @(posedge Clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    int frame_err_seen = 0;
    logic pop_en = 1'b0;
    logic stray_pop = 1'b0;
    logic [9:0] exp_q [$];
    logic [9:0] exp_ev;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // FrameErr pulse counter.
    initial forever begin
        @(negedge Clk);
        if (FrameErr === 1'b1) frame_err_seen++;
    end

    // Scoreboard consumer: compares the head event with the expected queue and pops.
    initial forever begin
        @(negedge Clk);
        if (pop_en && EvValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'({EvCode, EvExt, EvBreak}), 32'h3ff);
            end else begin
                exp_ev = exp_q.pop_front();
                check("event", 32'({EvCode, EvExt, EvBreak}), 32'(exp_ev));
            end
            EvPop = 1'b1;
        end else begin
            EvPop = stray_pop;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic ps2_bit(input logic b);
        KbdSerialData = b;
        repeat (HALF) @(negedge Clk);
        KbdClk = 1'b0;
        repeat (HALF) @(negedge Clk);
        KbdClk = 1'b1;
    endtask

    // Sends the first nbits of a frame (start, data LSB first, parity, stop).
    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop, input int nbits);
        logic [10:0] fr;
        fr = {stop, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
        KbdSerialData = 1'b1;
        repeat (HALF) @(negedge Clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || EvValid === 1'b1); i++) @(negedge Clk);
        check(name, 32'(exp_q.size()), 32'd0);
        check({name, "_empty"}, 32'(EvValid), 32'd0);
    endtask

    task automatic clear_err();
        @(negedge Clk) ClrErr = 1'b1;
        @(negedge Clk) ClrErr = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] b [4];
        int         n;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic set_vec(input int idx, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int n,
                           input logic [7:0] code, input logic ext, input logic brk);
        tbl[idx].b[0] = b0;
        tbl[idx].b[1] = b1;
        tbl[idx].b[2] = b2;
        tbl[idx].b[3] = b3;
        tbl[idx].n    = n;
        tbl[idx].exp  = {code, ext, brk};
    endtask

    // ---------------- main sequence ----------------
    int fe0;

    initial begin
        set_vec(0, 8'h1D, 8'h00, 8'h00, 8'h00, 1, 8'h1D, 1'b0, 1'b0);
        set_vec(1, 8'hF0, 8'h1D, 8'h00, 8'h00, 2, 8'h1D, 1'b0, 1'b1);
        set_vec(2, 8'hE0, 8'h75, 8'h00, 8'h00, 2, 8'h75, 1'b1, 1'b0);
        set_vec(3, 8'hE0, 8'hF0, 8'h75, 8'h00, 3, 8'h75, 1'b1, 1'b1);
        set_vec(4, 8'hF0, 8'hE0, 8'h75, 8'h00, 3, 8'h75, 1'b1, 1'b0);
        set_vec(5, 8'hF0, 8'hF0, 8'h1D, 8'h00, 3, 8'h1D, 1'b0, 1'b1);
        set_vec(6, 8'hE0, 8'hE0, 8'h12, 8'h00, 3, 8'h12, 1'b1, 1'b0);
        set_vec(7, 8'hE0, 8'hF0, 8'hF0, 8'h14, 4, 8'h14, 1'b1, 1'b1);

        // Reset state.
        repeat (5) @(negedge Clk);
        check("reset_outputs", 32'({EvValid, EvCode, EvExt, EvBreak, FrameErr, ParityErrSticky,
                                    TimeoutSticky, OverflowSticky, FifoCount}), 32'd0);
        RstN = 1'b1;
        repeat (5) @(negedge Clk);

        // Latency: good 1D frame, stop edge driven by hand.
        send_frame(8'h1D, 1'b0, 1'b1, 10);
        KbdClk = 1'b0;
        repeat (3) @(posedge Clk);
        #1 check("latency_not_yet", 32'(EvValid), 32'd0);
        @(posedge Clk);
        #1 check("latency_valid", 32'(EvValid), 32'd1);
        check("latency_count", 32'(FifoCount), 32'd1);
        check("latency_head", 32'({EvCode, EvExt, EvBreak}), 32'({8'h1D, 2'b00}));
        repeat (HALF) @(negedge Clk);
        KbdClk = 1'b1;
        repeat (HALF) @(negedge Clk);
        exp_q.push_back({8'h1D, 2'b00});
        pop_en = 1'b1;
        drain("drain_latency");

        // Stray pop while empty must not disturb the FIFO.
        stray_pop = 1'b1;
        repeat (4) @(negedge Clk);
        stray_pop = 1'b0;
        @(negedge Clk);
        check("stray_pop_count", 32'(FifoCount), 32'd0);

        // Edge in idle with data high: no error.
        fe0 = frame_err_seen;
        ps2_bit(1'b1);
        repeat (HALF) @(negedge Clk);
        check("idle_noise_no_err", 32'(frame_err_seen), 32'(fe0));

        // Table-driven decoder vectors.
        for (int v = 0; v < 8; v++) begin
            exp_q.push_back(tbl[v].exp);
            for (int j = 0; j < tbl[v].n; j++) send_frame(tbl[v].b[j], 1'b0, 1'b1, 11);
            drain($sformatf("vec%0d", v));
        end

        // F0 alone produces no event.
        pop_en = 1'b0;
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        check("f0_alone_count", 32'(FifoCount), 32'd0);
        exp_q.push_back({8'h1D, 2'b01});
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        check("f0_1d_count", 32'(FifoCount), 32'd1);
        pop_en = 1'b1;
        drain("drain_f0");

        // Parity error.
        fe0 = frame_err_seen;
        send_frame(8'h1D, 1'b1, 1'b1, 11);
        check("parity_frame_err", 32'(frame_err_seen), 32'(fe0 + 1));
        check("parity_sticky", 32'(ParityErrSticky), 32'd1);
        check("parity_count", 32'(FifoCount), 32'd0);
        clear_err();
        check("parity_cleared", 32'(ParityErrSticky), 32'd0);

        // Stop-bit error.
        fe0 = frame_err_seen;
        send_frame(8'h2A, 1'b0, 1'b0, 11);
        check("stop_frame_err", 32'(frame_err_seen), 32'(fe0 + 1));
        check("stop_sticky", 32'(ParityErrSticky), 32'd1);
        clear_err();

        // FrameErr resets a pending E0 prefix.
        exp_q.push_back({8'h1D, 2'b00});
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        send_frame(8'h22, 1'b1, 1'b1, 11);
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        drain("drain_err_base");
        clear_err();

        // Mid-frame timeout after data bit 3.
        fe0 = frame_err_seen;
        send_frame(8'h1C, 1'b0, 1'b1, 5);
        repeat (250) @(negedge Clk);
        check("tmo_frame_err", 32'(frame_err_seen), 32'(fe0 + 1));
        check("tmo_sticky", 32'(TimeoutSticky), 32'd1);
        check("tmo_fsm_idle", 32'(dbg_frame_st), 32'(ps2_kbd_pkg::FR_IDLE));
        check("tmo_count", 32'(FifoCount), 32'd0);
        exp_q.push_back({8'h1C, 2'b00});
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        drain("drain_tmo");
        clear_err();
        check("tmo_cleared", 32'(TimeoutSticky), 32'd0);

        // Overflow: 9 make codes, depth 8.
        pop_en = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k <= DEPTH) exp_q.push_back({8'(k), 2'b00});
            send_frame(8'(k), 1'b0, 1'b1, 11);
        end
        check("ovf_count", 32'(FifoCount), 32'(DEPTH));
        check("ovf_sticky", 32'(OverflowSticky), 32'd1);
        check("ovf_head", 32'({EvCode, EvExt, EvBreak}), 32'({8'h01, 2'b00}));
        pop_en = 1'b1;
        drain("drain_ovf");
        check("ovf_final_count", 32'(FifoCount), 32'd0);

        // Reset asserted mid-frame with content and stickies set.
        pop_en = 1'b0;
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        send_frame(8'h33, 1'b1, 1'b1, 11);
        check("pre_reset_count", 32'(FifoCount), 32'd1);
        fe0 = frame_err_seen;
        send_frame(8'h44, 1'b0, 1'b1, 4);
        @(negedge Clk) RstN = 1'b0;
        repeat (3) @(negedge Clk);
        check("midframe_reset_outputs", 32'({EvValid, EvCode, EvExt, EvBreak, FrameErr,
                                             ParityErrSticky, TimeoutSticky, OverflowSticky,
                                             FifoCount}), 32'd0);
        RstN = 1'b1;
        repeat (TMO + 50) @(negedge Clk);
        check("midframe_reset_no_err", 32'(frame_err_seen), 32'(fe0));
        exp_q.push_back({8'h5A, 2'b00});
        pop_en = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 11);
        drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
